// File: rtl/timer_sm_pkg.sv
// Shared types and helpers for the go/kill/pause timer state machine.
package timer_sm_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_PAUSED = 3'd2,
    ST_ABORT  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Busy covers every state in which a run is still in flight.
  function automatic logic state_busy(input state_e s);
    return (s == ST_ACTIVE) || (s == ST_PAUSED) || (s == ST_FINISH);
  endfunction

  // Six-character ASCII name for wave viewers and debug prints.
  function automatic logic [47:0] state_name(input logic [STATE_W-1:0] s);
    case (s)
      3'd0:    return "IDLE  ";
      3'd1:    return "ACTIVE";
      3'd2:    return "PAUSED";
      3'd3:    return "ABORT ";
      3'd4:    return "FINISH";
      default: return "ILLEGL";
    endcase
  endfunction

endpackage

// File: rtl/timer_sm_param_if.sv
// Control and status bundle between a timer client and timer_sm_param.
interface timer_sm_param_if #(
  parameter int unsigned WIDTH = 7
);
  logic             i_go;
  logic             i_kill;
  logic             i_pause;
  logic             i_reload;
  logic [WIDTH-1:0] i_term;
  logic [WIDTH-1:0] r_count;
  logic             o_done;
  logic             o_aborted;
  logic             o_busy;
  logic [2:0]       o_state;

  modport master (
    output i_go, i_kill, i_pause, i_reload, i_term,
    input  r_count, o_done, o_aborted, o_busy, o_state
  );

  modport slave (
    input  i_go, i_kill, i_pause, i_reload, i_term,
    output r_count, o_done, o_aborted, o_busy, o_state
  );
endinterface

// File: rtl/timer_sm_param.sv
// Counts 0..term after a go request, with pause, kill and optional auto-reload.
module timer_sm_param
  import timer_sm_pkg::*;
#(
  parameter int unsigned WIDTH        = 7,
  parameter int unsigned DEFAULT_TERM = 100
) (
  input  logic             i_clk,
  input  logic             reset,
  timer_sm_param_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             aborted_q, aborted_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             start_c;

  assign start_c = bus.i_go && !bus.i_kill;

  // Next-state selection; kill always wins outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_c) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (bus.i_kill)              state_d = ST_ABORT;
        else if (bus.i_pause)        state_d = ST_PAUSED;
        else if (count_q == term_q)  state_d = ST_FINISH;
      end
      ST_PAUSED: begin
        if (bus.i_kill)              state_d = ST_ABORT;
        else if (!bus.i_pause)       state_d = ST_ACTIVE;
      end
      ST_ABORT:  if (!bus.i_kill) state_d = ST_IDLE;
      ST_FINISH: begin
        if (bus.i_kill)              state_d = ST_ABORT;
        else if (bus.i_reload)       state_d = ST_ACTIVE;
        else                         state_d = ST_IDLE;
      end
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Count/term datapath; count can only advance while below the latched term.
  always_comb begin
    count_d   = count_q;
    term_d    = term_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          term_d    = bus.i_term;
          count_d   = '0;
          aborted_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (!bus.i_kill && !bus.i_pause && (count_q != term_q))
          count_d = count_q + WIDTH'(1);
      end
      ST_PAUSED: count_d = count_q;
      default:   count_d = '0;
    endcase
    if (state_d == ST_ABORT) begin
      count_d   = '0;
      aborted_d = 1'b1;
    end
    if (state_d == ST_FINISH) count_d = '0;
  end

  // Status flags are registered from the next state so they align with o_state.
  always_comb begin
    done_d = (state_d == ST_FINISH);
    busy_d = state_busy(state_d);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      term_q    <= WIDTH'(DEFAULT_TERM);
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      term_q    <= term_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.r_count   = count_q;
  assign bus.o_done    = done_q;
  assign bus.o_aborted = aborted_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_state   = state_q;

endmodule

// File: tb/tb_timer_sm_param.sv
// Directed bench for timer_sm_param; done pulses are checked against a queue of expected edges.
module tb_timer_sm_param;
  import timer_sm_pkg::*;

  localparam int unsigned WIDTH = 7;

  logic i_clk = 1'b0;
  logic reset;
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_q[$];

  timer_sm_param_if #(.WIDTH(WIDTH)) bus ();

  timer_sm_param #(.WIDTH(WIDTH), .DEFAULT_TERM(100)) dut (
    .i_clk (i_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_state(input string name, input state_e st);
    check(name, int'(bus.o_state), int'(st));
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge i_clk);
  endtask

  // Issue a one-cycle go; k is the edge at which it is accepted.
  task automatic go(input int term, output int k);
    bus.i_term = WIDTH'(term);
    bus.i_go   = 1'b1;
    k = edge_n + 1;
    @(negedge i_clk);
    bus.i_go   = 1'b0;
  endtask

  // Scoreboard monitor: every done pulse must match the next expected edge.
  always @(negedge i_clk) begin
    if (reset === 1'b0 && bus.o_done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", edge_n, -1);
      else                   check("done_edge", edge_n, exp_q.pop_front());
    end
  end

  initial begin
    int k;
    bus.i_go = 1'b0; bus.i_kill = 1'b0; bus.i_pause = 1'b0;
    bus.i_reload = 1'b0; bus.i_term = '0;
    reset = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_count", int'(bus.r_count), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_aborted", int'(bus.o_aborted), 0);
    check("rst_busy", int'(bus.o_busy), 0);
    check_state("rst_state", ST_IDLE);
    reset = 1'b0;
    @(negedge i_clk);

    // Basic run, term 5
    go(5, k); exp_q.push_back(k + 6);
    check_state("t5_active", ST_ACTIVE);
    check("t5_count0", int'(bus.r_count), 0);
    check("t5_busy", int'(bus.o_busy), 1);
    wait_edge(k + 5); check("t5_count5", int'(bus.r_count), 5);
    wait_edge(k + 6); check_state("t5_finish", ST_FINISH);
    check("t5_fin_count", int'(bus.r_count), 0);
    wait_edge(k + 7); check_state("t5_idle", ST_IDLE);
    check("t5_aborted", int'(bus.o_aborted), 0);
    check("t5_busy_idle", int'(bus.o_busy), 0);

    // Pause at count 4, sampled high on two edges
    go(10, k); exp_q.push_back(k + 14);
    wait_edge(k + 4); check("p_count4", int'(bus.r_count), 4);
    bus.i_pause = 1'b1;
    wait_edge(k + 6); check_state("p_paused", ST_PAUSED);
    check("p_held", int'(bus.r_count), 4);
    bus.i_pause = 1'b0;
    wait_edge(k + 7); check_state("p_resume", ST_ACTIVE);
    check("p_held2", int'(bus.r_count), 4);
    wait_edge(k + 8); check("p_count5", int'(bus.r_count), 5);
    wait_edge(k + 15); check_state("p_idle", ST_IDLE);

    // Kill at count 7, held for two edges
    go(20, k);
    wait_edge(k + 7); check("k_count7", int'(bus.r_count), 7);
    bus.i_kill = 1'b1;
    wait_edge(k + 8); check_state("k_abort", ST_ABORT);
    check("k_count0", int'(bus.r_count), 0);
    check("k_aborted", int'(bus.o_aborted), 1);
    check("k_busy", int'(bus.o_busy), 0);
    wait_edge(k + 9); check_state("k_abort_hold", ST_ABORT);
    bus.i_kill = 1'b0;
    wait_edge(k + 10); check_state("k_idle", ST_IDLE);
    check("k_sticky", int'(bus.o_aborted), 1);
    go(2, k); exp_q.push_back(k + 3);
    check("k_clear", int'(bus.o_aborted), 0);
    wait_edge(k + 4); check_state("k2_idle", ST_IDLE);

    // Auto-reload, term 3: period of 5 edges
    bus.i_reload = 1'b1;
    go(3, k);
    exp_q.push_back(k + 4); exp_q.push_back(k + 9); exp_q.push_back(k + 14);
    wait_edge(k + 5); check_state("r_reactive", ST_ACTIVE);
    check("r_count0", int'(bus.r_count), 0);
    wait_edge(k + 10);
    bus.i_reload = 1'b0;
    wait_edge(k + 15); check_state("r_idle", ST_IDLE);

    // Term 0
    go(0, k); exp_q.push_back(k + 1);
    check_state("z_active", ST_ACTIVE);
    wait_edge(k + 1); check_state("z_finish", ST_FINISH);
    wait_edge(k + 2); check_state("z_idle", ST_IDLE);

    // Term at the maximum representable value
    go(127, k); exp_q.push_back(k + 128);
    wait_edge(k + 127); check("m_count127", int'(bus.r_count), 127);
    check_state("m_active", ST_ACTIVE);
    wait_edge(k + 128); check("m_fin_count", int'(bus.r_count), 0);
    check_state("m_finish", ST_FINISH);
    wait_edge(k + 129); check_state("m_idle", ST_IDLE);

    // Go together with kill in IDLE is blocked
    bus.i_term = WIDTH'(5); bus.i_go = 1'b1; bus.i_kill = 1'b1;
    @(negedge i_clk);
    check_state("gk_idle", ST_IDLE);
    check("gk_busy", int'(bus.o_busy), 0);
    bus.i_go = 1'b0; bus.i_kill = 1'b0;
    @(negedge i_clk);
    check_state("gk_idle2", ST_IDLE);

    // Reset mid-run restores every output and the default term
    go(90, k);
    wait_edge(k + 50); check("rm_count50", int'(bus.r_count), 50);
    reset = 1'b1;
    wait_edge(k + 51);
    check("rm_count", int'(bus.r_count), 0);
    check("rm_done", int'(bus.o_done), 0);
    check("rm_aborted", int'(bus.o_aborted), 0);
    check("rm_busy", int'(bus.o_busy), 0);
    check_state("rm_state", ST_IDLE);
    check("rm_term", int'(dut.term_q), 100);
    reset = 1'b0;
    wait_edge(k + 55);
    check_state("rm_idle", ST_IDLE);
    check("pending_done", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
